// File: rtl/voice_mix_scheduler_if.sv
// DAC-side sample handshake between the voice mixer and its consumer.
interface voice_mix_scheduler_if #(
  parameter int WIDTH = 24
);
  logic signed [WIDTH-1:0] sample_out;
  logic                    sample_valid;
  logic                    sample_ready;

  modport master (
    output sample_out,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_out,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/voice_mix_scheduler.sv
// Steps all voices through one shared oscillator per sample tick,
// mixes the enabled ones, scales by master volume and saturates.
module voice_mix_scheduler #(
  parameter int N_VOICES = 8,
  parameter int WIDTH    = 24,
  parameter int LAT      = 3
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        sample_tick,
  input  logic [N_VOICES-1:0]         voice_en,
  input  logic [7:0]                  master_vol,
  output logic [$clog2(N_VOICES)-1:0] osc_idx,
  output logic                        osc_step,
  input  logic signed [WIDTH-1:0]     osc_data,
  voice_mix_scheduler_if.master       dac,
  output logic                        busy,
  output logic                        overrun
);

  localparam int IW    = $clog2(N_VOICES);
  localparam int ACC_W = WIDTH + IW;
  localparam int PW    = ACC_W + 9;

  localparam logic [LAT-1:0] LOW_MASK = {LAT{1'b1}} >> 1;
  localparam logic signed [PW-1:0] SMAX =
    {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {
    IDLE, ISSUE, DRAIN, SCALE, HOLD
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]           idx;
  logic [N_VOICES-1:0]     snap_en;
  logic [7:0]              snap_vol;
  logic [LAT-1:0]          tag_v;
  logic [LAT-1:0]          tag_e;
  logic signed [ACC_W-1:0] acc;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    res;
  logic signed [WIDTH-1:0] sat;
  logic                    start;
  logic                    push;

  assign start    = (state == IDLE) && sample_tick;
  assign push     = (state == ISSUE);
  assign osc_step = push;
  assign osc_idx  = idx;
  assign busy     = (state != IDLE);
  assign dac.sample_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (sample_tick) state_nx = ISSUE;
      ISSUE: if (idx == IW'(N_VOICES-1)) state_nx = DRAIN;
      // only the pipe output may still be in flight
      DRAIN: if ((tag_v & LOW_MASK) == '0) state_nx = SCALE;
      SCALE: state_nx = HOLD;
      HOLD:  if (dac.sample_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx      <= '0;
      snap_en  <= '0;
      snap_vol <= '0;
      tag_v    <= '0;
      tag_e    <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= sample_tick && (state != IDLE);
      tag_v   <= (tag_v << 1) | LAT'(push);
      tag_e   <= (tag_e << 1) | LAT'(push & snap_en[idx]);
      if (start) begin
        idx      <= '0;
        snap_en  <= voice_en;
        snap_vol <= master_vol;
      end else if (push) begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc <= '0;
    end else if (start) begin
      acc <= '0;
    end else if (tag_v[LAT-1] && tag_e[LAT-1]) begin
      acc <= acc + $signed({{IW{osc_data[WIDTH-1]}}, osc_data});
    end
  end

  assign prod = PW'(acc) * PW'($signed({1'b0, snap_vol}));
  assign res  = prod >>> 8;

  always_comb begin
    sat = res[WIDTH-1:0];
    if (res > SMAX)      sat = SMAX[WIDTH-1:0];
    else if (res < SMIN) sat = SMIN[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn)               dac.sample_out <= '0;
    else if (state == SCALE) dac.sample_out <= sat;
  end

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Scoreboard bench: frames push expected samples, a monitor pops
// and compares on every accepted handshake.
module tb_voice_mix_scheduler;
  localparam int N   = 8;
  localparam int W   = 24;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sample_tick = 1'b0;
  logic [N-1:0] voice_en = '0;
  logic [7:0] master_vol = '0;
  logic [2:0] osc_idx;
  logic osc_step;
  logic busy;
  logic overrun;
  logic signed [W-1:0] osc_data;

  voice_mix_scheduler_if #(.WIDTH(W)) dac_if ();

  voice_mix_scheduler #(.N_VOICES(N), .WIDTH(W), .LAT(LAT)) dut (
    .clk(clk),
    .rstn(rstn),
    .sample_tick(sample_tick),
    .voice_en(voice_en),
    .master_vol(master_vol),
    .osc_idx(osc_idx),
    .osc_step(osc_step),
    .osc_data(osc_data),
    .dac(dac_if),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int mode = 0;
  longint exp_q[$];

  // oscillator model: answers LAT cycles after each step
  logic       pv [LAT];
  logic [2:0] pi [LAT];

  always @(posedge clk) begin
    pv[0] <= osc_step;
    pi[0] <= osc_idx;
    for (int k = 1; k < LAT; k++) begin
      pv[k] <= pv[k-1];
      pi[k] <= pi[k-1];
    end
  end

  always_comb begin
    osc_data = 24'h5A5A5A;
    if (pv[LAT-1] === 1'b1) begin
      case (mode)
        0: osc_data = 24'(1000 * (int'(pi[LAT-1]) + 1));
        1: osc_data = 24'h7FFFFF;
        2: osc_data = 24'h800000;
        default: osc_data = -24'sd3;
      endcase
    end
  end

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && dac_if.sample_valid && dac_if.sample_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: got %0d expected none",
                 $signed(dac_if.sample_out));
      end else begin
        check("sample_out", $signed(dac_if.sample_out),
              exp_q.pop_front());
      end
    end
  end

  task automatic run_frame(input logic [7:0] en, input logic [7:0] vol,
                           input longint exp, input bit chk_lat,
                           input bit tgl);
    int steps = 0;
    int first = 0;
    int last = 0;
    int idx_err = 0;
    int vcyc = 0;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    voice_en = en;
    master_vol = vol;
    sample_tick = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) begin
        @(posedge clk);
        #1 sample_tick = 1'b0;
      end
      @(negedge clk);
      if (tgl && c == 3) begin
        voice_en = ~en;
        master_vol = 8'd1;
      end
      if (osc_step) begin
        if (first == 0) first = c;
        last = c;
        if (osc_idx != 3'(steps)) idx_err++;
        steps++;
      end
      if (sample_valid_now() && vcyc == 0) vcyc = c;
      if (vcyc != 0) break;
    end
    check("valid_seen", longint'(vcyc != 0), 1);
    if (chk_lat) begin
      check("step_count", steps, N);
      check("step_first", first, 1);
      check("step_last", last, N);
      check("osc_idx_order", idx_err, 0);
      check("valid_cycle", vcyc, N + LAT + 2);
    end
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    check("idle_after_frame", busy, 0);
  endtask

  function automatic bit sample_valid_now();
    return dac_if.sample_valid;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [W-1:0] held;
    int unstable;
    int ov;
    int stray;
    int vcnt;
    dac_if.sample_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", dac_if.sample_valid, 0);
    check("rst_step", osc_step, 0);
    check("rst_overrun", overrun, 0);
    check("rst_idx", osc_idx, 0);
    check("rst_sample_out", $signed(dac_if.sample_out), 0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // T1..T4 and extra gain points
    mode = 0;
    run_frame(8'h00, 8'd255, 0, 1'b1, 1'b0);
    run_frame(8'b0000_1001, 8'd128, 2500, 1'b1, 1'b0);
    run_frame(8'hFF, 8'd255, 35859, 1'b0, 1'b0);
    run_frame(8'hFF, 8'd0, 0, 1'b0, 1'b0);
    mode = 1;
    run_frame(8'hFF, 8'd255, 8388607, 1'b0, 1'b0);
    mode = 2;
    run_frame(8'hFF, 8'd255, -8388608, 1'b0, 1'b0);
    mode = 3;
    run_frame(8'h01, 8'd1, -1, 1'b0, 1'b0);

    // T5: backpressure, overrun in HOLD and in the handshake cycle
    mode = 0;
    dac_if.sample_ready = 1'b0;
    exp_q.push_back(2000);
    @(posedge clk);
    #1;
    voice_en = 8'h80;
    master_vol = 8'd64;
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    for (int c = 0; c < 40 && !dac_if.sample_valid; c++) @(negedge clk);
    check("hold_valid", dac_if.sample_valid, 1);
    held = dac_if.sample_out;
    unstable = 0;
    ov = 0;
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 sample_tick = (i == 50);
      @(negedge clk);
      if (!dac_if.sample_valid || dac_if.sample_out !== held) unstable++;
      if (overrun) ov++;
      if (osc_step || !busy) stray++;
    end
    check("hold_stable", unstable, 0);
    check("hold_overrun_pulses", ov, 1);
    check("hold_no_new_frame", stray, 0);
    check("hold_data", $signed(held), 2000);
    @(posedge clk);
    #1;
    dac_if.sample_ready = 1'b1;
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    @(negedge clk);
    check("hs_valid_drop", dac_if.sample_valid, 0);
    check("hs_overrun", overrun, 1);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || osc_step) stray++;
    end
    check("hs_tick_dropped", stray, 0);
    run_frame(8'b0000_1001, 8'd128, 2500, 1'b1, 1'b0);

    // T6: reset in the 4th ISSUE cycle, then snapshot check
    @(posedge clk);
    #1;
    voice_en = 8'hFF;
    master_vol = 8'd255;
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    check("rst4_idx", osc_idx, 3);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst4_step", osc_step, 0);
    check("rst4_busy", busy, 0);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dac_if.sample_valid) vcnt++;
    end
    check("rst4_no_valid", vcnt, 0);
    run_frame(8'h02, 8'd255, 1992, 1'b1, 1'b1);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
